pipe_stage: RTL and testbench

Parametrised elastic pipeline register placed between processor stages (fetch/decode, decode/execute, execute/memory, memory/writeback). It carries one packed payload word with a valid/ready handshake, and supports a synchronous flush for branch squashing. An optional skid slot keeps the upstream ready signal fully registered. A saturating stall counter supports performance analysis.

---
 rtl/pipe_pkg.sv | 53 +++++
 rtl/pipe_sat_counter.sv | 38 +++
 rtl/pipe_stage.sv | 105 ++++++++++
 tb/tb_pipe_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the processor pipeline registers.
//   PC_W / XLEN      : program-counter and datapath widths.
//   *_payload_t      : packed field sets carried across each stage boundary.
//                      Instantiate pipe_stage with DATA_W = $bits(<stage>_payload_t).
package pipe_pkg;

  localparam int PC_W = 12;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_payload_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    alu_op_e         alu_op;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } id_ex_payload_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] store_val;
    logic [4:0]      rd;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } ex_mem_payload_t;

  typedef struct packed {
    logic [XLEN-1:0] wb_val;
    logic [4:0]      rd;
    logic            reg_wr;
  } mem_wb_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: up-counter that sticks at its all-ones maximum.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   en_i       : count this cycle
//   cnt_o      : current count (registered)
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: elastic valid/ready pipeline register with flush and stall counter.
//   DATA_W : payload width; SKID : 1 = two-entry skid (registered in_ready),
//            0 = single entry (combinational in_ready); CNT_W : stall counter width.
//   clk, rst_n (async, active-low), flush (synchronous squash of held entries)
//   in_valid / in_ready / in_data    : upstream handshake
//   out_valid / out_ready / out_data : downstream handshake
//   stall_cnt : saturating count of cycles with out_valid && !out_ready
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic              push_s;
  logic              pop_s;

  // With a skid slot, in_ready comes straight from a flop; without it, a
  // popping main entry can be refilled in the same cycle.
  assign in_ready = (SKID != 0) ? !skid_v_q : (!main_v_q || out_ready);
  assign push_s   = in_valid && in_ready;
  assign pop_s    = main_v_q && out_ready;

  // Next-state for main and skid entries. Flush wins and drops any push;
  // data registers are left untouched on flush.
  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (SKID != 0) begin
      if (pop_s && skid_v_q) begin
        // in_ready is low here, so no push can coincide.
        main_d_d = skid_d_q;
        skid_v_d = 1'b0;
      end else if (push_s && (!main_v_q || pop_s)) begin
        main_v_d = 1'b1;
        main_d_d = in_data;
      end else if (push_s) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data;
      end else if (pop_s) begin
        main_v_d = 1'b0;
      end else begin
        main_v_d = main_v_q;
      end
    end else begin
      if (push_s) begin
        main_v_d = 1'b1;
        main_d_d = in_data;
      end else if (pop_s) begin
        main_v_d = 1'b0;
      end else begin
        main_v_d = main_v_q;
      end
    end
  end

  // Entry registers; reset empties both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      main_d_q <= {DATA_W{1'b0}};
      skid_v_q <= 1'b0;
      skid_d_q <= {DATA_W{1'b0}};
    end else begin
      main_v_q <= main_v_d;
      main_d_q <= main_d_d;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_data  = main_d_q;

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (main_v_q && !out_ready),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // u1: SKID=1, CNT_W=2
  logic        f1 = 1'b0, v1 = 1'b0, r1 = 1'b0;
  logic [31:0] d1 = 32'd0;
  logic        ir1, ov1;
  logic [31:0] od1;
  logic [1:0]  sc1;

  // u0: SKID=0, CNT_W=16
  logic        f0 = 1'b0, v0 = 1'b0, r0 = 1'b0;
  logic [31:0] d0 = 32'd0;
  logic        ir0, ov0;
  logic [31:0] od0;
  logic [15:0] sc0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage #(.DATA_W(32), .SKID(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(f1), .in_valid(v1), .in_ready(ir1),
    .in_data(d1), .out_valid(ov1), .out_ready(r1), .out_data(od1), .stall_cnt(sc1)
  );

  pipe_stage #(.DATA_W(32), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(f0), .in_valid(v0), .in_ready(ir0),
    .in_data(d0), .out_valid(ov0), .out_ready(r0), .out_data(od0), .stall_cnt(sc0)
  );

  typedef struct {
    logic        fl;
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    f1 = 1'b0; v1 = 1'b0; r1 = 1'b0; d1 = 32'd0;
    f0 = 1'b0; v0 = 1'b0; r0 = 1'b0; d0 = 32'd0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_sc[6];
    int sent1, got1, sent0, got0;

    //            fl    v     d              rdy   e_ir  e_ov  e_od
    tbl[0]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001};
    tbl[1]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'hA5A5_0001};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 32'h0000_0011};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0022, 1'b0, 1'b0, 1'b1, 32'h0000_0011};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 32'h0000_0011};
    tbl[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0022};
    tbl[6]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0022};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0044, 1'b1, 1'b1, 1'b1, 32'h0000_0044};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_0055, 1'b1, 1'b1, 1'b1, 32'h0000_0055};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_0066, 1'b0, 1'b0, 1'b1, 32'h0000_0055};
    tbl[10] = '{1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b1, 1'b0, 32'h0000_0055};
    tbl[11] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0055};
    tbl[12] = '{1'b0, 1'b1, 32'h0000_0077, 1'b1, 1'b1, 1'b1, 32'h0000_0077};
    tbl[13] = '{1'b1, 1'b1, 32'h0000_0088, 1'b0, 1'b1, 1'b0, 32'h0000_0077};
    tbl[14] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0077};
    exp_sc = '{1, 2, 3, 3, 3, 3};

    // Reset state of both modes
    do_reset();
    #1;
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_od1", od1, 32'd0);
    chk("rst_ir1", 32'(ir1), 32'd1);
    chk("rst_sc1", 32'(sc1), 32'd0);
    chk("rst_ov0", 32'(ov0), 32'd0);
    chk("rst_ir0", 32'(ir0), 32'd1);
    chk("rst_sc0", 32'(sc0), 32'd0);

    // Table-driven sequence on the SKID=1 stage
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      f1 = tbl[i].fl; v1 = tbl[i].v; d1 = tbl[i].d; r1 = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ov", i), 32'(ov1), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_od", i), od1, tbl[i].e_od);
      chk($sformatf("tbl%0d_ir", i), 32'(ir1), 32'(tbl[i].e_ir));
    end

    // SKID=0: single entry, combinational in_ready, push+pop replace
    do_reset();
    @(negedge clk);
    v0 = 1'b1; d0 = 32'h5; r0 = 1'b0;
    @(posedge clk);
    #1;
    chk("s0_ov", 32'(ov0), 32'd1);
    chk("s0_od", od0, 32'h5);
    chk("s0_ir_full", 32'(ir0), 32'd0);
    r0 = 1'b1;
    #1;
    chk("s0_ir_comb", 32'(ir0), 32'd1);
    @(negedge clk);
    v0 = 1'b1; d0 = 32'h6; r0 = 1'b1;
    @(posedge clk);
    #1;
    chk("s0_replace_od", od0, 32'h6);
    chk("s0_replace_ov", 32'(ov0), 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    @(posedge clk);
    #1;
    chk("s0_drain_ov", 32'(ov0), 32'd0);

    // Saturating stall counter (CNT_W=2), unaffected by flush
    do_reset();
    @(negedge clk);
    v1 = 1'b1; d1 = 32'h1; r1 = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      v1 = 1'b0; r1 = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d", k), 32'(sc1), 32'(exp_sc[k]));
    end
    @(negedge clk);
    f1 = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_flush_ov", 32'(ov1), 32'd0);
    chk("stall_flush_cnt", 32'(sc1), 32'd3);
    @(negedge clk);
    f1 = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_after_flush", 32'(sc1), 32'd3);

    // Stream 0..15 through both modes with random out_ready
    do_reset();
    sent1 = 0; got1 = 0; sent0 = 0; got0 = 0;
    for (int cyc = 0; cyc < 400 && (got1 < 16 || got0 < 16); cyc++) begin
      @(negedge clk);
      v1 = (sent1 < 16); d1 = 32'(sent1); r1 = 1'($urandom_range(0, 1));
      v0 = (sent0 < 16); d0 = 32'(sent0); r0 = 1'($urandom_range(0, 1));
      #1;
      if (ov1 && r1) begin
        chk("stream1", od1, 32'(got1));
        got1++;
      end
      if (v1 && ir1) sent1++;
      if (ov0 && r0) begin
        chk("stream0", od0, 32'(got0));
        got0++;
      end
      if (v0 && ir0) sent0++;
    end
    @(negedge clk);
    v1 = 1'b0; r1 = 1'b0; v0 = 1'b0; r0 = 1'b0;
    chk("stream1_count", 32'(got1), 32'd16);
    chk("stream0_count", 32'(got0), 32'd16);

    // Asynchronous reset mid-cycle with both entries full
    do_reset();
    @(negedge clk);
    v1 = 1'b1; d1 = 32'h11; r1 = 1'b0;
    v0 = 1'b1; d0 = 32'h11; r0 = 1'b0;
    @(negedge clk);
    v1 = 1'b1; d1 = 32'h22;
    v0 = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_arst_ir1", 32'(ir1), 32'd0);
    chk("pre_arst_ov0", 32'(ov0), 32'd1);
    #2;
    v1 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_ov1", 32'(ov1), 32'd0);
    chk("arst_od1", od1, 32'd0);
    chk("arst_ir1", 32'(ir1), 32'd1);
    chk("arst_sc1", 32'(sc1), 32'd0);
    chk("arst_ov0", 32'(ov0), 32'd0);
    chk("arst_od0", od0, 32'd0);
    chk("arst_ir0", 32'(ir0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
